// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported instruction/data RAM between fetch and the memory stage.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a requester holds req/addr/we/wdata until it sees gnt in the same
  // cycle; gnt is combinational and read data returns exactly one cycle later.

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

  owner_e      owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        resp_pend_q, resp_pend_d;
  logic        resp_sel_q, resp_sel_d;
  logic        fetch_forced;

  always_comb begin
    f_gnt        = 1'b0;
    d_gnt        = 1'b0;
    fetch_forced = f_req && (starve_cnt_q == STARVE_LIM);
    if (!rst) begin
      if (d_req && !fetch_forced) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
    end
  end

  always_comb begin
    owner_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    resp_pend_d  = mem_en & !mem_we;
    resp_sel_d   = d_gnt;
    if (d_gnt) begin
      owner_d = DATA;
    end else if (f_gnt) begin
      owner_d = FETCH;
    end
    // The counter measures data wins while fetch is actually waiting.
    if (f_gnt || !f_req) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= IDLE;
      starve_cnt_q <= '0;
      resp_pend_q  <= 1'b0;
      resp_sel_q   <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      resp_pend_q  <= resp_pend_d;
      resp_sel_q   <= resp_sel_d;
    end
  end

  // Gated by rst so a read in flight when reset arrives is dropped, not delivered.
  always_comb begin
    f_rvalid = resp_pend_q & !resp_sel_q & !rst;
    d_rvalid = resp_pend_q &  resp_sel_q & !rst;
    f_rdata  = f_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

  a_owner_matches_resp : assert property (@(posedge clk) disable iff (rst)
    resp_pend_q |-> (owner_q == (resp_sel_q ? DATA : FETCH)));

  a_starve_bounded : assert property (@(posedge clk) disable iff (rst)
    starve_cnt_q <= STARVE_LIM);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked by a transaction-level reference model and a response scoreboard.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Write-first single-port RAM attached to the arbiter's command port.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] ram_rdata = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) ram_rdata <= ram[mem_addr[7:0]];
  end
  assign mem_rdata = ram_rdata;

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [0:255];
  int unsigned   data_wins_while_waiting;
  logic [DW-1:0] exp_q[$];
  logic          exp_port_q[$];   // 0 = fetch, 1 = data
  int            exp_due_q[$];
  int            cycle = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, req);
  endtask

  // Monitor: sampled at negedge, mid-cycle, after inputs settled at posedge+1.
  always @(negedge clk) begin
    logic          e_f, e_d, e_fv, e_dv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_fd, e_dd;
    e_f = 1'b0; e_d = 1'b0;
    if (!rst) begin
      if (d_req && !(f_req && data_wins_while_waiting == SM)) e_d = 1'b1;
      else if (f_req) e_f = 1'b1;
    end
    e_addr  = e_d ? d_addr : (e_f ? f_addr : '0);
    e_wdata = e_d ? d_wdata : '0;
    check("grant", {f_gnt, d_gnt}, {e_f, e_d});
    check("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata},
          {e_f | e_d, e_d & d_we, e_addr, e_wdata});

    e_fv = 1'b0; e_dv = 1'b0; e_fd = '0; e_dd = '0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cycle) begin
      if (!rst) begin
        if (exp_port_q[0]) begin e_dv = 1'b1; e_dd = exp_q[0]; end
        else               begin e_fv = 1'b1; e_fd = exp_q[0]; end
      end
      void'(exp_q.pop_front()); void'(exp_port_q.pop_front()); void'(exp_due_q.pop_front());
    end
    check("rresp", {f_rvalid, d_rvalid, f_rdata, d_rdata}, {e_fv, e_dv, e_fd, e_dd});

    if (rst) begin
      data_wins_while_waiting = 0;
      exp_q.delete(); exp_port_q.delete(); exp_due_q.delete();
    end else begin
      if (e_d && d_we) ref_mem[d_addr[7:0]] = d_wdata;
      if (e_d && !d_we) begin
        exp_q.push_back(ref_mem[d_addr[7:0]]); exp_port_q.push_back(1'b1); exp_due_q.push_back(cycle + 1);
      end
      if (e_f) begin
        exp_q.push_back(ref_mem[f_addr[7:0]]); exp_port_q.push_back(1'b0); exp_due_q.push_back(cycle + 1);
      end
      if (e_f || !f_req) data_wins_while_waiting = 0;
      else if (e_d && data_wins_while_waiting < SM) data_wins_while_waiting++;
    end
    cycle++;
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input logic r, input logic fr, input logic [AW-1:0] fa,
                           input logic dr, input logic dwe, input logic [AW-1:0] da,
                           input logic [DW-1:0] dwd, output logic fg, output logic dg);
    @(posedge clk); #1;
    rst = r; f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    fg = f_gnt; dg = d_gnt;
  endtask

  task automatic idle(input int n);
    logic fg, dg;
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, fg, dg);
  endtask

  // Randomized traffic: each requester holds its request until granted.
  task automatic random_phase(input int ncyc, input int fprob, input int dprob, input int rstprob);
    logic fr, dr, dwe, fg, dg, r;
    logic [AW-1:0] fa, da;
    logic [DW-1:0] dwd;
    int   f_wait, d_wait;
    fr = 1'b0; dr = 1'b0; dwe = 1'b0; fa = '0; da = '0; dwd = '0; fg = 1'b0; dg = 1'b0;
    f_wait = 0; d_wait = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (fg) fr = 1'b0;
      if (dg) dr = 1'b0;
      if (!fr) begin
        fa = AW'($urandom_range(0, 255));
        fr = ($urandom_range(0, 99) < fprob);
      end
      if (!dr) begin
        da  = AW'($urandom_range(0, 255));
        dwe = 1'($urandom_range(0, 1));
        dwd = DW'($urandom);
        dr  = ($urandom_range(0, 99) < dprob);
      end
      r = ($urandom_range(0, 999) < rstprob);
      run_cycle(r, fr, fa, dr, dwe, da, dwd, fg, dg);
      f_wait = (fr && !fg) ? f_wait + 1 : 0;
      d_wait = (dr && !dg) ? d_wait + 1 : 0;
      if (f_wait > 40 || d_wait > 40) begin
        check("grant_timeout", {f_wait[7:0], d_wait[7:0]}, 16'h0);
        break;
      end
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic fg, dg;
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    data_wins_while_waiting = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;

    // Reset with both requesters asserted; data must win first after release.
    run_cycle(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, '0, fg, dg);
    check("rst_no_gnt0", {fg, dg}, 2'b00);
    run_cycle(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, '0, fg, dg);
    check("rst_no_gnt1", {fg, dg}, 2'b00);
    run_cycle(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, '0, fg, dg);
    check("first_after_rst", {fg, dg}, 2'b01);
    run_cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, fg, dg);
    check("fetch_after_rst", {fg, dg}, 2'b10);
    idle(2);

    // Single fetch of 0xBEEF.
    run_cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, fg, dg);
    check("single_fetch_gnt", {fg, dg, mem_en, mem_addr}, {3'b101, 16'h0010});
    run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, fg, dg);
    check("single_fetch_data", {f_rvalid, f_rdata}, {1'b1, 16'hBEEF});

    // Store then load the same address on consecutive cycles.
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'h0040, 16'h1234, fg, dg);
    check("store_cmd", {dg, mem_we, d_rvalid}, 3'b110);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0040, '0, fg, dg);
    check("load_gnt", {dg, mem_we, d_rvalid}, 3'b100);
    run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, fg, dg);
    check("load_data", {d_rvalid, d_rdata}, {1'b1, 16'h1234});

    // Continuous contention: d,d,d,d,f repeating.
    idle(1);
    for (int i = 0; i < 15; i++) begin
      run_cycle(1'b0, 1'b1, 16'(i), 1'b1, 1'b0, 16'(i + 100), '0, fg, dg);
      check("starve_pattern", {fg, dg}, (i % 5 == 4) ? 2'b10 : 2'b01);
    end
    idle(2);

    // Reset the edge after a load grant: response must be dropped.
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0030, '0, fg, dg);
    check("midread_gnt", {fg, dg}, 2'b01);
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, fg, dg);
    check("midread_drop", {d_rvalid, f_rvalid}, 2'b00);
    run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, fg, dg);
    check("midread_after", {d_rvalid, f_rvalid, mem_en}, 3'b000);

    // Randomized phases: saturation, sparse with gaps, mixed with occasional reset.
    random_phase(300, 100, 100, 0);
    random_phase(400, 30, 30, 0);
    random_phase(800, 70, 60, 8);
    idle(3);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported 16-bit instruction/data RAM between the fetch stage and the memory stage, downstream of execute. Execute supplies `addr`/`store_data`. Each cycle the block grants the port to one requester and drives the RAM command. It then returns read data to the owner one cycle later. Data accesses have priority, and a starvation counter guarantees fetch forward progress.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- f_req  in  1  fetch read request; held until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (execute `addr`)
- d_wdata  in  DATA_W  store data (execute `store_data`)
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read

## Operation
- State: `owner` FSM {IDLE, FETCH, DATA}, meaning the grant of the previous cycle; `starve_cnt` (4 bits); `resp_pend` (1 bit); `resp_sel` (1 bit: 0 = fetch, 1 = data).
- Grant decision (combinational, same cycle):
  - If rst is high, no grant.
  - Else if d_req and not (f_req and starve_cnt == STARVE_MAX), grant data.
  - Else if f_req, grant fetch.
  - Else no grant.
- Exactly one of f_gnt and d_gnt is high, or neither.
- RAM command follows the grant combinationally:
  - mem_en = f_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata come from the granted requester; mem_wdata = 0 on a fetch grant.
  - With no grant, all mem_* outputs are 0.
- FSM next state is DATA on d_gnt, FETCH on f_gnt, else IDLE.
- starve_cnt:
  - Increments on d_gnt & f_req.
  - Clears on f_gnt or on !f_req.
  - Saturates at STARVE_MAX.
- Response tracking:
  - resp_pend <= mem_en & !mem_we.
  - resp_sel <= d_gnt.
  - Stores produce no response.
- Read return:
  - f_rvalid = resp_pend & !resp_sel.
  - d_rvalid = resp_pend & resp_sel.
  - The matching rdata is mem_rdata; the non-owner rdata is 0.
- A store followed by a load to the same address on the next cycle returns the new data. The RAM is write-first and the arbiter does no reordering.

## Timing
- Reset (rst high at an edge):
  - owner = IDLE, starve_cnt = 0, resp_pend = 0, resp_sel = 0.
  - All outputs are 0 during and after reset until a request arrives.
- Grant latency is 0 cycles: gnt is high in the same cycle as req when that requester wins.
- Read latency is 1 cycle: rvalid is high exactly in the cycle after the grant, for exactly 1 cycle.
- Back-to-back grants are allowed every cycle. Full throughput is one access per cycle.
- A requester must keep req, addr, we and wdata stable until its gnt is seen. After gnt it may change them in the next cycle.
- Simultaneous f_req and d_req:
  - Data wins while starve_cnt < STARVE_MAX.
  - Once starve_cnt == STARVE_MAX, fetch wins in that cycle and the counter clears at the edge.
- Reset during an outstanding read: resp_pend clears and no rvalid is produced; the response is dropped.
- Reset has priority over all other updates in the same edge.
- starve_cnt never exceeds STARVE_MAX; there is no wrap.

## Test plan
- Reset: drive rst for 2 cycles with f_req = d_req = 1. Required: all outputs 0; first grant is d_gnt in the cycle after rst falls.
- Single fetch: f_req = 1, f_addr = 0x0010, RAM[0x10] = 0xBEEF. Required: f_gnt and mem_en in the same cycle, mem_addr = 0x0010; next cycle f_rvalid = 1 and f_rdata = 0xBEEF.
- Store then load: d_we = 1, d_addr = 0x0040, d_wdata = 0x1234, then a load of 0x0040. Required:
  - Cycle 1: mem_we = 1, no d_rvalid.
  - Cycle 2: load granted.
  - Cycle 3: d_rvalid = 1, d_rdata = 0x1234.
- Starvation, STARVE_MAX = 4: hold f_req and d_req high continuously. Required: the grant pattern repeats d, d, d, d, f. Every fetch grant is followed by f_rvalid, with d_rvalid never high in the same cycle.
- Reset mid-read: grant a data load, then assert rst on the next edge. Required: d_rvalid stays 0 and resp_pend = 0.
- Idle gaps: alternate requests with empty cycles. Required: no spurious gnt, rvalid or mem_en; starve_cnt = 0 after any cycle with f_req low.
